// File: rtl/decompressor_input_parser.sv
// decompressor_input_parser
//
// Front end of the LZRW1 decompressor. Takes the compressed stream one byte
// at a time, pulls out each control byte, builds one 16-bit item per control
// bit and offers it to the decompressor until it is accepted.
//
// Ports:
//   clock             - system clock, rising edge
//   reset             - synchronous, active-low
//   byte_in[7:0]      - compressed stream byte
//   byte_in_valid     - byte_in is valid
//   byte_in_last      - final byte of the stream (qualified by byte_in_valid)
//   byte_in_ready     - parser takes byte_in this cycle
//   decompressor_busy - decompressor cannot take an item this cycle
//   data_in[15:0]     - item: {8'h00, byte} for a literal, {hi, lo} for a copy
//   control_word_in   - 1 = copy item, 0 = literal
//   data_in_valid     - data_in / control_word_in are valid
//   parse_done        - one-cycle pulse when a stream ends
//   format_error      - sticky: a stream ended inside a copy item
//   item_count        - items accepted by the decompressor since reset (wraps)
module decompressor_input_parser #(
  parameter int COUNT_WIDTH = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [7:0]             byte_in,
  input  logic                   byte_in_valid,
  input  logic                   byte_in_last,
  output logic                   byte_in_ready,
  input  logic                   decompressor_busy,
  output logic [15:0]            data_in,
  output logic                   control_word_in,
  output logic                   data_in_valid,
  output logic                   parse_done,
  output logic                   format_error,
  output logic [COUNT_WIDTH-1:0] item_count
);

  typedef enum logic [2:0] {
    ST_CTRL    = 3'd0,
    ST_ITEM_LO = 3'd1,
    ST_ITEM_HI = 3'd2,
    ST_PRESENT = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t                 state_r;
  logic [7:0]             ctrl_byte_r;
  logic [2:0]             bit_idx_r;
  logic                   last_r;
  logic [7:0]             hi_byte_r;
  logic                   ready_r;
  logic                   valid_r;
  logic                   done_r;
  logic                   error_r;
  logic [15:0]            data_r;
  logic                   cw_r;
  logic [COUNT_WIDTH-1:0] count_r;

  logic byte_xfer_s;
  logic item_xfer_s;
  logic cur_bit_s;

  assign byte_xfer_s = byte_in_valid && ready_r;
  assign item_xfer_s = valid_r && !decompressor_busy;
  // The first item of a group uses the MSB of the control byte.
  assign cur_bit_s   = ctrl_byte_r[3'd7 - bit_idx_r];

  // Parser state machine; every output is registered and ready is set
  // together with the state it belongs to.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_r     <= ST_CTRL;
      ctrl_byte_r <= 8'h00;
      bit_idx_r   <= 3'd0;
      last_r      <= 1'b0;
      hi_byte_r   <= 8'h00;
      ready_r     <= 1'b1;
      valid_r     <= 1'b0;
      done_r      <= 1'b0;
      error_r     <= 1'b0;
      data_r      <= 16'h0000;
      cw_r        <= 1'b0;
      count_r     <= '0;
    end else begin
      // parse_done is a single-cycle pulse unless re-armed below.
      done_r <= 1'b0;
      case (state_r)
        ST_CTRL: begin
          if (byte_xfer_s) begin
            ctrl_byte_r <= byte_in;
            bit_idx_r   <= 3'd0;
            if (byte_in_last) begin
              // Stream consisting of a bare control byte: no item.
              state_r <= ST_DONE;
              ready_r <= 1'b0;
              done_r  <= 1'b1;
            end else begin
              state_r <= ST_ITEM_LO;
            end
          end
        end
        ST_ITEM_LO: begin
          if (byte_xfer_s) begin
            if (!cur_bit_s) begin
              data_r  <= {8'h00, byte_in};
              cw_r    <= 1'b0;
              last_r  <= byte_in_last;
              state_r <= ST_PRESENT;
              ready_r <= 1'b0;
              valid_r <= 1'b1;
            end else if (!byte_in_last) begin
              hi_byte_r <= byte_in;
              state_r   <= ST_ITEM_HI;
            end else begin
              // Stream ended after the first byte of a copy.
              error_r <= 1'b1;
              state_r <= ST_DONE;
              ready_r <= 1'b0;
              done_r  <= 1'b1;
            end
          end
        end
        ST_ITEM_HI: begin
          if (byte_xfer_s) begin
            data_r  <= {hi_byte_r, byte_in};
            cw_r    <= 1'b1;
            last_r  <= byte_in_last;
            state_r <= ST_PRESENT;
            ready_r <= 1'b0;
            valid_r <= 1'b1;
          end
        end
        ST_PRESENT: begin
          if (item_xfer_s) begin
            count_r <= count_r + COUNT_WIDTH'(1);
            valid_r <= 1'b0;
            if (last_r) begin
              // Remaining control bits of this group are ignored.
              last_r  <= 1'b0;
              state_r <= ST_DONE;
              done_r  <= 1'b1;
            end else if (bit_idx_r == 3'd7) begin
              state_r <= ST_CTRL;
              ready_r <= 1'b1;
            end else begin
              bit_idx_r <= bit_idx_r + 3'd1;
              state_r   <= ST_ITEM_LO;
              ready_r   <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          last_r  <= 1'b0;
          state_r <= ST_CTRL;
          ready_r <= 1'b1;
        end
        default: begin
          state_r <= ST_CTRL;
          ready_r <= 1'b1;
          valid_r <= 1'b0;
          last_r  <= 1'b0;
        end
      endcase
    end
  end

  assign byte_in_ready   = ready_r;
  assign data_in         = data_r;
  assign control_word_in = cw_r;
  assign data_in_valid   = valid_r;
  assign parse_done      = done_r;
  assign format_error    = error_r;
  assign item_count      = count_r;

endmodule

// File: tb/tb_decompressor_input_parser.sv
// Self-checking bench for decompressor_input_parser: a byte-list parser model
// predicts the item sequence and error flag of every stream; a monitor checks
// the DUT each cycle, with directed streams followed by random streams.
module tb_decompressor_input_parser;

  localparam int CW = 5;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    byte_in = 8'h00;
  logic          byte_in_valid = 1'b0;
  logic          byte_in_last = 1'b0;
  logic          byte_in_ready;
  logic          decompressor_busy = 1'b0;
  logic [15:0]   data_in;
  logic          control_word_in;
  logic          data_in_valid;
  logic          parse_done;
  logic          format_error;
  logic [CW-1:0] item_count;

  always #5 clock = ~clock;

  decompressor_input_parser #(.COUNT_WIDTH(CW)) dut (
    .clock             (clock),
    .reset             (reset),
    .byte_in           (byte_in),
    .byte_in_valid     (byte_in_valid),
    .byte_in_last      (byte_in_last),
    .byte_in_ready     (byte_in_ready),
    .decompressor_busy (decompressor_busy),
    .data_in           (data_in),
    .control_word_in   (control_word_in),
    .data_in_valid     (data_in_valid),
    .parse_done        (parse_done),
    .format_error      (format_error),
    .item_count        (item_count)
  );

  typedef struct packed {
    logic [15:0] d;
    logic        c;
  } item_t;

  item_t       exp_q[$];
  bit          err_q[$];
  item_t       exp_item;
  int          tests = 0;
  int          fails = 0;
  int          exp_count = 0;
  bit          err_sofar = 1'b0;
  int          done_seen = 0;
  int          streams_sent = 0;
  logic [15:0] last_d = 16'h0000;
  logic        last_c = 1'b0;
  int          busy_mode = 1;   // 0 random, 1 never busy, 2 always busy
  bit          gaps_en = 1'b0;
  bit          prev_valid = 1'b0;
  bit          prev_busy = 1'b0;
  bit          prev_done = 1'b0;
  logic [15:0] prev_d = 16'h0000;
  logic        prev_c = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s: event did not occur as required", name);
  endtask

  // Reference model: walk the byte list as the stream format describes.
  function automatic void model_parse(input logic [7:0] bs[$]);
    int         i = 0;
    int         n = bs.size();
    bit         err = 1'b0;
    logic [7:0] c;
    while (i < n) begin
      c = bs[i];
      i++;
      for (int k = 0; k < 8 && i < n; k++) begin
        if (c[7-k]) begin
          if (i + 1 >= n) begin
            err = 1'b1;
            i = n;
          end else begin
            exp_q.push_back({bs[i], bs[i+1], 1'b1});
            i += 2;
          end
        end else begin
          exp_q.push_back({8'h00, bs[i], 1'b0});
          i++;
        end
      end
    end
    err_q.push_back(err);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit last);
    int waited = 0;
    bit sent = 1'b0;
    if (gaps_en) begin
      repeat ($urandom_range(0, 2)) begin
        @(negedge clock);
        byte_in_valid = 1'b0;
      end
    end
    while (!sent && waited < 500) begin
      @(negedge clock);
      byte_in       = b;
      byte_in_last  = last;
      byte_in_valid = 1'b1;
      if (byte_in_ready) begin
        @(posedge clock);
        sent = 1'b1;
      end
      waited++;
    end
    #1 byte_in_valid = 1'b0;
    if (!sent) fail_now("byte_accept_timeout");
  endtask

  task automatic send_stream(input logic [7:0] bs[$]);
    model_parse(bs);
    streams_sent++;
    for (int i = 0; i < bs.size(); i++) send_byte(bs[i], (i == bs.size() - 1));
  endtask

  task automatic wait_idle();
    int w = 0;
    while (!(done_seen == streams_sent && exp_q.size() == 0) && w < 3000) begin
      @(negedge clock);
      w++;
    end
    if (w >= 3000) fail_now("idle_timeout");
    repeat (2) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset         = 1'b0;
    byte_in_valid = 1'b0;
    exp_q.delete();
    err_q.delete();
    exp_count    = 0;
    err_sofar    = 1'b0;
    streams_sent = done_seen;
    repeat (2) @(posedge clock);
    @(negedge clock);
    #1;
    check("rst_ready", 32'(byte_in_ready), 32'd1);
    check("rst_valid", 32'(data_in_valid), 32'd0);
    check("rst_data", 32'(data_in), 32'h0000);
    check("rst_cw", 32'(control_word_in), 32'd0);
    check("rst_done", 32'(parse_done), 32'd0);
    check("rst_error", 32'(format_error), 32'd0);
    check("rst_count", 32'(item_count), 32'd0);
    reset = 1'b1;
    @(negedge clock);
    #1;
    check("ready_after_release", 32'(byte_in_ready), 32'd1);
  endtask

  // Busy driver.
  initial begin
    forever begin
      @(negedge clock);
      case (busy_mode)
        0:       decompressor_busy = ($urandom_range(0, 2) == 0);
        2:       decompressor_busy = 1'b1;
        default: decompressor_busy = 1'b0;
      endcase
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    forever begin
      @(negedge clock);
      #2;
      if (reset) begin
        if (parse_done) begin
          if (prev_done) fail_now("done_pulse_width");
          done_seen++;
          if (err_q.size() > 0) err_sofar = err_sofar | err_q.pop_front();
          else fail_now("unexpected_done");
        end
        check("format_error", 32'(format_error), 32'(err_sofar));
        check("item_count", 32'(item_count), 32'(exp_count));
        if (prev_valid && prev_busy) begin
          check("hold_valid", 32'(data_in_valid), 32'd1);
          check("hold_data", 32'(data_in), 32'(prev_d));
          check("hold_cw", 32'(control_word_in), 32'(prev_c));
        end
        if (data_in_valid) begin
          check("ready_low_in_present", 32'(byte_in_ready), 32'd0);
          if (!decompressor_busy) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_item");
            end else begin
              exp_item = exp_q.pop_front();
              check("item_data", 32'(data_in), 32'(exp_item.d));
              check("item_cw", 32'(control_word_in), 32'(exp_item.c));
            end
            exp_count = (exp_count + 1) % (1 << CW);
            last_d    = data_in;
            last_c    = control_word_in;
          end
        end
        prev_valid = data_in_valid;
        prev_busy  = decompressor_busy;
        prev_d     = data_in;
        prev_c     = control_word_in;
        prev_done  = parse_done;
      end else begin
        prev_valid = 1'b0;
        prev_done  = 1'b0;
      end
    end
  end

  // Watchdog.
  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // Stimulus.
  initial begin
    logic [7:0] s[$];
    logic [7:0] c;
    int         n;
    int         w;

    do_reset();

    // Literal then copy.
    s = '{8'h40, 8'h41, 8'h01, 8'h02};
    send_stream(s);
    wait_idle();
    check("t1_count", 32'(item_count), 32'd2);
    check("t1_last_data", 32'(last_d), 32'h0102);
    check("t1_last_cw", 32'(last_c), 32'd1);
    check("t1_done_pulses", 32'(done_seen), 32'd1);

    // Full group rollover.
    s = '{8'h00, 8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68,
          8'h80, 8'h10, 8'h03};
    send_stream(s);
    wait_idle();
    check("t2_count", 32'(item_count), 32'd11);
    check("t2_last_data", 32'(last_d), 32'h1003);
    check("t2_last_cw", 32'(last_c), 32'd1);

    // Backpressure: five busy cycles while an item is presented.
    busy_mode = 2;
    s = '{8'h00, 8'h77};
    send_stream(s);
    w = 0;
    while (!data_in_valid && w < 50) begin
      @(negedge clock);
      #3;
      w++;
    end
    if (!data_in_valid) fail_now("bp_valid_timeout");
    for (int i = 0; i < 5; i++) begin
      check("bp_ready", 32'(byte_in_ready), 32'd0);
      check("bp_valid", 32'(data_in_valid), 32'd1);
      check("bp_data", 32'(data_in), 32'h0077);
      @(negedge clock);
      #3;
    end
    busy_mode = 1;
    wait_idle();
    check("bp_count", 32'(item_count), 32'd12);

    // Control byte only.
    s = '{8'hFF};
    send_stream(s);
    wait_idle();
    check("ctrl_only_count", 32'(item_count), 32'd12);
    check("ctrl_only_done", 32'(done_seen), 32'd4);

    // Truncated copy, then a normal stream with the error still set.
    s = '{8'h80, 8'h22};
    send_stream(s);
    wait_idle();
    check("trunc_error", 32'(format_error), 32'd1);
    check("trunc_count", 32'(item_count), 32'd12);
    s = '{8'h00, 8'h99};
    send_stream(s);
    wait_idle();
    check("post_trunc_count", 32'(item_count), 32'd13);
    check("post_trunc_data", 32'(last_d), 32'h0099);
    check("post_trunc_error", 32'(format_error), 32'd1);

    // Reset in the middle of a copy item.
    send_byte(8'h80, 1'b0);
    send_byte(8'h33, 1'b0);
    do_reset();
    s = '{8'h00, 8'h55};
    send_stream(s);
    wait_idle();
    check("after_rst_count", 32'(item_count), 32'd1);
    check("after_rst_data", 32'(last_d), 32'h0055);
    check("after_rst_cw", 32'(last_c), 32'd0);

    // Random streams with valid gaps, random busy and occasional truncation.
    gaps_en   = 1'b1;
    busy_mode = 0;
    for (int st = 0; st < 40; st++) begin
      n = $urandom_range(0, 19);
      s.delete();
      c = 8'h00;
      if (n == 0) begin
        s.push_back(8'($urandom));
      end else begin
        for (int j = 0; j < n; j++) begin
          if (j % 8 == 0) begin
            c = 8'($urandom);
            s.push_back(c);
          end
          s.push_back(8'($urandom));
          if (c[7 - (j % 8)]) s.push_back(8'($urandom));
        end
        if (c[7 - ((n - 1) % 8)] && $urandom_range(0, 5) == 0) void'(s.pop_back());
      end
      send_stream(s);
    end
    wait_idle();
    busy_mode = 1;
    check("rand_all_done", 32'(done_seen), 32'(streams_sent));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
